// File: rtl/gumnut_timer_port.sv
// Programmable interval timer on the Gumnut I/O port bus: four byte registers,
// prescaled down-counter with sticky expiry flag and level-held interrupt request.
module gumnut_timer_port #(
  parameter logic [7:0]  BASE_ADDR = 8'h10,
  parameter int unsigned PRESCALE  = 50
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       port_cyc_i,
  input  logic       port_stb_i,
  input  logic       port_we_i,
  input  logic [7:0] port_adr_i,
  input  logic [7:0] port_dat_i,
  output logic       port_ack_o,
  output logic [7:0] port_dat_o,
  output logic       int_req_o,
  input  logic       int_ack_i
);

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  typedef enum logic [1:0] {BUS_IDLE, BUS_ACK, BUS_HOLD} bus_state_e;

  bus_state_e  bus_q, bus_d;
  logic [7:0]  reload_q, reload_d;
  logic [7:0]  count_q, count_d;
  logic [15:0] pre_q, pre_d;
  logic        en_q, en_d, ie_q, ie_d, per_q, per_d;
  logic        exp_q, exp_d, int_q, int_d;
  logic [7:0]  rdata_q, rdata_d;

  logic        hit, accept, wr;
  logic        wr_reload, wr_ctrl, wr_status, exp_clr;
  logic        en_rise, cnt_load, tick, expire;

  assign hit       = port_cyc_i & port_stb_i & (port_adr_i[7:2] == BASE_ADDR[7:2]);
  assign accept    = hit & (bus_q == BUS_IDLE);
  assign wr        = accept & port_we_i;
  assign wr_reload = wr & (port_adr_i[1:0] == 2'd0);
  assign wr_ctrl   = wr & (port_adr_i[1:0] == 2'd1);
  assign wr_status = wr & (port_adr_i[1:0] == 2'd2);
  assign exp_clr   = wr_status & port_dat_i[0];
  assign en_rise   = wr_ctrl & port_dat_i[0] & ~en_q;
  assign cnt_load  = wr_reload | en_rise;
  assign tick      = en_q & (pre_q == '0);
  // A count-loading write swallows a coincident tick, including its expiry.
  assign expire    = tick & (count_q == '0) & ~cnt_load;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus_q    <= BUS_IDLE;
      reload_q <= '0;
      count_q  <= '0;
      pre_q    <= PRE_MAX;
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      per_q    <= 1'b0;
      exp_q    <= 1'b0;
      int_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      bus_q    <= bus_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      pre_q    <= pre_d;
      en_q     <= en_d;
      ie_q     <= ie_d;
      per_q    <= per_d;
      exp_q    <= exp_d;
      int_q    <= int_d;
      rdata_q  <= rdata_d;
    end
  end

  // One ack per strobe: after acking, wait for stb to drop before re-arming.
  always_comb begin
    bus_d = bus_q;
    unique case (bus_q)
      BUS_IDLE: if (hit) bus_d = BUS_ACK;
      BUS_ACK:  bus_d = port_stb_i ? BUS_HOLD : BUS_IDLE;
      BUS_HOLD: if (!port_stb_i) bus_d = BUS_IDLE;
      default:  bus_d = BUS_IDLE;
    endcase
  end

  always_comb begin
    port_ack_o = (bus_q == BUS_ACK);
    port_dat_o = port_ack_o ? rdata_q : '0;
    int_req_o  = int_q;
  end

  always_comb begin
    reload_d = reload_q;
    count_d  = count_q;
    pre_d    = pre_q;
    en_d     = en_q;
    ie_d     = ie_q;
    per_d    = per_q;
    exp_d    = exp_q;
    int_d    = int_q;
    rdata_d  = rdata_q;

    if (!en_q || cnt_load || tick) pre_d = PRE_MAX;
    else                           pre_d = pre_q - 16'd1;

    if (wr_reload) reload_d = port_dat_i;

    if (cnt_load) begin
      count_d = wr_reload ? port_dat_i : reload_q;
    end else if (tick) begin
      if (count_q != '0) count_d = count_q - 8'd1;
      else if (per_q)    count_d = reload_q;
    end

    if (wr_ctrl) begin
      en_d  = port_dat_i[0];
      ie_d  = port_dat_i[1];
      per_d = port_dat_i[2];
    end else if (expire && !per_q) begin
      en_d = 1'b0;
    end

    if (exp_clr) exp_d = 1'b0;
    if (expire)  exp_d = 1'b1;

    if (int_ack_i || exp_clr) int_d = 1'b0;
    if (expire && ie_q)       int_d = 1'b1;

    if (accept) begin
      unique case (port_adr_i[1:0])
        2'd0:    rdata_d = reload_q;
        2'd1:    rdata_d = {5'b0, per_q, ie_q, en_q};
        2'd2:    rdata_d = {7'b0, exp_q};
        default: rdata_d = count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_gumnut_timer_port.sv
// Directed + randomized checks of gumnut_timer_port against an arithmetic
// model of count value and expiry time since the last count load.
module tb_gumnut_timer_port;

  localparam int unsigned PRE = 4;
  localparam logic [7:0]  BASE = 8'h10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cyc, stb, we, iack;
  logic [7:0] adr, wdat;
  logic       ack, irq;
  logic [7:0] rdat;

  int unsigned cnt = 0;
  int unsigned errors = 0;
  int unsigned checks = 0;

  // Model: count loaded with mR at edge t0 with prescaler reset.
  int unsigned t0, mR;
  bit          mper, mrun;

  gumnut_timer_port #(.BASE_ADDR(BASE), .PRESCALE(PRE)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .port_cyc_i(cyc), .port_stb_i(stb), .port_we_i(we),
    .port_adr_i(adr), .port_dat_i(wdat),
    .port_ack_o(ack), .port_dat_o(rdat),
    .int_req_o(irq), .int_ack_i(iack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] mcount(input int unsigned t);
    int unsigned n;
    if (!mrun) return 8'(mR);
    n = (t - t0) / PRE;
    if (mper) return 8'(mR - (n % (mR + 1)));
    return (n <= mR) ? 8'(mR - n) : 8'd0;
  endfunction

  function automatic bit mexp(input int unsigned t);
    return mrun && (((t - t0) / PRE) >= mR + 1);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_edge(input int unsigned t);
    while (cnt < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic access(input logic w, input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output int unsigned he);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    @(posedge clk); #1;
    he = cnt;
    chk("ack", {7'b0, ack}, 8'h01);
    rd = rdat;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wrt(input logic [7:0] a, input logic [7:0] d, output int unsigned he);
    logic [7:0] unused_rd;
    access(1'b1, a, d, unused_rd, he);
  endtask

  task automatic rdv(input logic [7:0] a, output logic [7:0] rd, output int unsigned he);
    access(1'b0, a, 8'h00, rd, he);
  endtask

  task automatic nohit(input logic [7:0] a);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    repeat (2) begin
      @(posedge clk); #1;
      chk("nohit_ack", {7'b0, ack}, 8'h00);
      chk("nohit_dat", rdat, 8'h00);
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
  endtask

  initial begin
    logic [7:0]  rd;
    int unsigned h, e, k;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; iack = 1'b0;
    adr = '0; wdat = '0;
    mrun = 1'b0; mper = 1'b0; mR = 0; t0 = 0;

    #23;
    chk("rst_ack", {7'b0, ack}, 8'h00);
    chk("rst_dat", rdat, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      rdv(BASE + 8'(i), rd, h);
      chk("rst_reg", rd, 8'h00);
    end
    nohit(8'h14);
    nohit(8'h0F);
    chk("idle_irq", {7'b0, irq}, 8'h00);

    // Strobe held for several cycles yields exactly one ack.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE;
    @(posedge clk); #1;
    chk("hold_ack1", {7'b0, ack}, 8'h01);
    repeat (2) begin
      @(posedge clk); #1;
      chk("hold_ack0", {7'b0, ack}, 8'h00);
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    chk("hold_rel", {7'b0, ack}, 8'h00);

    // Periodic: RELOAD=3, PRESCALE=4 -> expiry every 16 cycles.
    wrt(BASE + 8'd0, 8'd3, h);
    wrt(BASE + 8'd1, 8'h07, e);
    t0 = e; mR = 3; mper = 1'b1; mrun = 1'b1;
    wait_edge(e + 15);
    chk("per_irq_pre", {7'b0, irq}, 8'h00);
    wait_edge(e + 16);
    chk("per_irq_rise", {7'b0, irq}, 8'h01);
    for (int i = 0; i < 4; i++) begin
      wait_edge(e + 16 + 4 * i + 1);
      rdv(BASE + 8'd3, rd, h);
      chk("count_seq", rd, 8'(3 - i));
    end
    wait_edge(e + 31);
    @(negedge clk) iack = 1'b1;
    @(posedge clk); #1;
    chk("ack_vs_expiry", {7'b0, irq}, 8'h01);
    @(posedge clk); #1;
    chk("ack_clears", {7'b0, irq}, 8'h00);
    @(negedge clk) iack = 1'b0;
    rdv(BASE + 8'd2, rd, h);
    chk("exp_sticky", rd, 8'h01);
    wait_edge(e + 47);
    chk("per_irq_pre2", {7'b0, irq}, 8'h00);
    wait_edge(e + 48);
    chk("per_irq_rise2", {7'b0, irq}, 8'h01);

    // Randomized reload / mode / observation point.
    for (int trial = 0; trial < 10; trial++) begin
      mrun = 1'b0;
      wrt(BASE + 8'd1, 8'h00, h);
      wrt(BASE + 8'd2, 8'h01, h);
      mR = $urandom_range(0, 6);
      mper = 1'($urandom_range(0, 1));
      wrt(BASE + 8'd0, 8'(mR), h);
      wrt(BASE + 8'd1, mper ? 8'h07 : 8'h03, e);
      t0 = e; mrun = 1'b1;
      k = $urandom_range(0, 40);
      wait_edge(e + k);
      rdv(BASE + 8'd3, rd, h);
      chk("rnd_count", rd, mcount(h - 1));
      rdv(BASE + 8'd2, rd, h);
      chk("rnd_status", rd, {7'b0, mexp(h - 1)});
      rdv(BASE + 8'd1, rd, h);
      chk("rnd_ctrl", rd, {5'b0, mper, 1'b1, mper | ~mexp(h - 1)});
      chk("rnd_irq", {7'b0, irq}, {7'b0, mexp(cnt)});
    end

    // One-shot with RELOAD=2: single expiry 12 cycles after enable.
    mrun = 1'b0;
    wrt(BASE + 8'd1, 8'h00, h);
    wrt(BASE + 8'd2, 8'h01, h);
    chk("clr_irq", {7'b0, irq}, 8'h00);
    wrt(BASE + 8'd0, 8'd2, h);
    wrt(BASE + 8'd1, 8'h03, e);
    wait_edge(e + 11);
    chk("os_irq_pre", {7'b0, irq}, 8'h00);
    wait_edge(e + 12);
    chk("os_irq_rise", {7'b0, irq}, 8'h01);
    rdv(BASE + 8'd1, rd, h);
    chk("os_ctrl", rd, 8'h02);
    rdv(BASE + 8'd3, rd, h);
    chk("os_count", rd, 8'h00);
    @(negedge clk) iack = 1'b1;
    @(posedge clk); #1;
    chk("os_ack", {7'b0, irq}, 8'h00);
    @(negedge clk) iack = 1'b0;
    rdv(BASE + 8'd2, rd, h);
    chk("os_exp", rd, 8'h01);
    wrt(BASE + 8'd2, 8'h01, h);
    rdv(BASE + 8'd2, rd, h);
    chk("os_exp_clr", rd, 8'h00);
    repeat (30) @(posedge clk);
    #1;
    chk("os_quiet_irq", {7'b0, irq}, 8'h00);
    rdv(BASE + 8'd3, rd, h);
    chk("os_quiet_cnt", rd, 8'h00);

    // RELOAD write landing on a tick edge: no decrement of the new value.
    wrt(BASE + 8'd0, 8'd7, h);
    wrt(BASE + 8'd1, 8'h07, e);
    wait_edge(e + 7);
    wrt(BASE + 8'd0, 8'd5, h);
    t0 = h; mR = 5; mper = 1'b1; mrun = 1'b1;
    rdv(BASE + 8'd3, rd, e);
    chk("tick_wr_count", rd, 8'd5);
    wait_edge(h + 9);
    rdv(BASE + 8'd3, rd, e);
    chk("tick_wr_later", rd, mcount(e - 1));
    wait_edge(h + 25);
    chk("pre_rst_irq", {7'b0, irq}, 8'h01);

    // Reset in the middle of an acknowledged transfer.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 8'd3;
    @(posedge clk); #1;
    chk("mid_ack", {7'b0, ack}, 8'h01);
    #1 rst_n = 1'b0;
    #1;
    chk("async_ack", {7'b0, ack}, 8'h00);
    chk("async_dat", rdat, 8'h00);
    chk("async_irq", {7'b0, irq}, 8'h00);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_irq", {7'b0, irq}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      rdv(BASE + 8'(i), rd, h);
      chk("post_reg", rd, 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
